// File: rtl/instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Purpose:
//   Control sequencer for fetching an instruction from byte-wide memory. A
//   fetch reads two bytes into IR (low byte, then high byte). It then shifts
//   ExtLen (0..3) extra operand bytes into DR. The PC is incremented on every
//   memory read cycle. Done pulses for one cycle at the end of the fetch.
//   This is a Moore machine: every control output is decoded from the
//   registered state only.
//
// Optional feature:
//   FETCH_ABORT_EN -- when defined, adds the Abort input. Abort=1 in any busy
//   state returns the machine to IDLE on the next edge, with no Done pulse.
//
// Ports:
//   Clock        in   system clock
//   Reset        in   asynchronous active-low reset (0 resets)
//   Req          in   fetch request, sampled only in IDLE
//   ExtLen[1:0]  in   extra operand bytes to fetch, latched when Req is accepted
//   Abort        in   (FETCH_ABORT_EN only) abandon the current fetch
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle completion pulse
//   Mem_CS       out  memory chip select, 0 enables memory
//   Mem_WR       out  memory write strobe, tied to 0 (read only)
//   IR_Write     out  IR load enable
//   IR_LH        out  IR half select (0 = IR[7:0], 1 = IR[15:8])
//   ARF_OutDSel  out  address register file output-D select (memory address)
//   ARF_FunSel   out  address register file function select
//   ARF_RegSel   out  address register file register enables
//   DR_E         out  data register enable
//   DR_FunSel    out  data register function select
//   MuxCSel      out  MuxC source select (2'b11 routes MemOut)
// ---------------------------------------------------------------------------
module instruction_fetch_sequencer #(
  parameter logic [1:0] PC_INC_FUNSEL  = 2'b01,
  parameter logic [2:0] PC_REGSEL      = 3'b100,
  parameter logic [1:0] OUTD_PC        = 2'b00,
  parameter logic [1:0] DR_LOAD_FUNSEL = 2'b10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req,
  input  logic [1:0] ExtLen,
`ifdef FETCH_ABORT_EN
  input  logic       Abort,
`endif
  output logic       Busy,
  output logic       Done,
  output logic       Mem_CS,
  output logic       Mem_WR,
  output logic       IR_Write,
  output logic       IR_LH,
  output logic [1:0] ARF_OutDSel,
  output logic [1:0] ARF_FunSel,
  output logic [2:0] ARF_RegSel,
  output logic       DR_E,
  output logic [1:0] DR_FunSel,
  output logic [1:0] MuxCSel
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_L = 3'd1;
  localparam logic [2:0] FETCH_H = 3'd2;
  localparam logic [2:0] EXT     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0] stateReg;
  logic [2:0] stateNext;
  // Number of operand bytes still to fetch. It is loaded from ExtLen when a
  // request is accepted, so later changes to ExtLen have no effect.
  logic [1:0] cntReg;
  logic [1:0] cntNext;

  // State and counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateReg <= IDLE;
      cntReg   <= 2'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (Req) begin
          stateNext = FETCH_L;
          cntNext   = ExtLen;
        end
      end
      FETCH_L: stateNext = FETCH_H;
      FETCH_H: stateNext = (cntReg == 2'd0) ? DONE : EXT;
      EXT: begin
        cntNext = cntReg - 2'd1;
        // The "<=" also covers cntReg == 0. Normal operation never enters
        // EXT with a zero count. If it did, the machine leaves EXT instead
        // of wrapping around to 3.
        if (cntReg <= 2'd1) begin
          stateNext = DONE;
        end
      end
      // Done has already been raised for this one cycle. A request seen
      // here is not accepted. It is taken only after the machine is in IDLE.
      DONE: stateNext = IDLE;
      // Unused encodings go back to IDLE on the next edge.
      default: begin
        stateNext = IDLE;
        cntNext   = 2'd0;
      end
    endcase
`ifdef FETCH_ABORT_EN
    // Abort takes priority over the normal transitions. Strobes issued
    // before the abort are not undone. The PC keeps whatever increments it
    // already received.
    if (Abort && (stateReg != IDLE)) begin
      stateNext = IDLE;
      cntNext   = 2'd0;
    end
`endif
  end

  // Output decode. The outputs depend on the state only.
  always_comb begin
    Busy        = 1'b0;
    Done        = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    IR_Write    = 1'b0;
    IR_LH       = 1'b0;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;
    MuxCSel     = 2'b00;
    case (stateReg)
      FETCH_L, FETCH_H: begin
        Busy        = 1'b1;
        Mem_CS      = 1'b0;
        ARF_OutDSel = OUTD_PC;
        IR_Write    = 1'b1;
        IR_LH       = (stateReg == FETCH_H);
        ARF_RegSel  = PC_REGSEL;
        ARF_FunSel  = PC_INC_FUNSEL;
      end
      EXT: begin
        Busy        = 1'b1;
        Mem_CS      = 1'b0;
        ARF_OutDSel = OUTD_PC;
        ARF_RegSel  = PC_REGSEL;
        ARF_FunSel  = PC_INC_FUNSEL;
        DR_E        = 1'b1;
        DR_FunSel   = DR_LOAD_FUNSEL;
        MuxCSel     = 2'b11;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_sequencer
//
// Directed testbench for instruction_fetch_sequencer with default parameters.
// All outputs are packed into one 18-bit vector:
//   {Busy, Done, Mem_CS, Mem_WR, IR_Write, IR_LH, ARF_OutDSel, ARF_FunSel,
//    ARF_RegSel, DR_E, DR_FunSel, MuxCSel}
// This vector is compared against hand-written per-state constants.
// PC increments and Done pulses are counted at every falling edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Req;
  logic [1:0] ExtLen;
`ifdef FETCH_ABORT_EN
  logic       Abort;
`endif
  logic       Busy;
  logic       Done;
  logic       Mem_CS;
  logic       Mem_WR;
  logic       IR_Write;
  logic       IR_LH;
  logic [1:0] ARF_OutDSel;
  logic [1:0] ARF_FunSel;
  logic [2:0] ARF_RegSel;
  logic       DR_E;
  logic [1:0] DR_FunSel;
  logic [1:0] MuxCSel;

  instruction_fetch_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .ExtLen     (ExtLen),
`ifdef FETCH_ABORT_EN
    .Abort      (Abort),
`endif
    .Busy       (Busy),
    .Done       (Done),
    .Mem_CS     (Mem_CS),
    .Mem_WR     (Mem_WR),
    .IR_Write   (IR_Write),
    .IR_LH      (IR_LH),
    .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel (ARF_FunSel),
    .ARF_RegSel (ARF_RegSel),
    .DR_E       (DR_E),
    .DR_FunSel  (DR_FunSel),
    .MuxCSel    (MuxCSel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Expected output vectors, one per state, written out by hand.
  //                                 Bsy   Dn    CS    WR    IRW   LH    OutD   Fun    Reg     DRE   DRF    Mux
  localparam logic [17:0] V_IDLE = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
  localparam logic [17:0] V_FL   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 3'b100, 1'b0, 2'b00, 2'b00};
  localparam logic [17:0] V_FH   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 3'b100, 1'b0, 2'b00, 2'b00};
  localparam logic [17:0] V_EXT  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b100, 1'b1, 2'b10, 2'b11};
  localparam logic [17:0] V_DONE = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};

  logic [17:0] outs;
  assign outs = {Busy, Done, Mem_CS, Mem_WR, IR_Write, IR_LH, ARF_OutDSel,
                 ARF_FunSel, ARF_RegSel, DR_E, DR_FunSel, MuxCSel};

  int testCount = 0;
  int failCount = 0;
  int pcIncs    = 0;
  int doneCount = 0;
  int pcBase;
  int doneBase;

  // Counts PC increment strobes and Done pulses once per cycle.
  always @(negedge Clock) begin
    if ((ARF_RegSel == 3'b100) && (ARF_FunSel == 2'b01)) pcIncs <= pcIncs + 1;
    if (Done) doneCount <= doneCount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
      else begin
        failCount++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset  = 1'b0;
    Req    = 1'b0;
    ExtLen = 2'd0;
`ifdef FETCH_ABORT_EN
    Abort  = 1'b0;
`endif

    // Reset state, then release with Req low.
    @(negedge Clock);
    check("reset_outs", 32'(outs), 32'(V_IDLE));
    Reset = 1'b1;
    nextCycle();
    check("idle_after_release", 32'(outs), 32'(V_IDLE));
    nextCycle();
    check("idle_req0", 32'(outs), 32'(V_IDLE));

    // Fetch with ExtLen=0: FL, FH, then Done at cycle 3. PC advances by 2.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd0;
    nextCycle(); check("e0_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0;
    nextCycle(); check("e0_c2_fh", 32'(outs), 32'(V_FH));
    nextCycle(); check("e0_c3_done", 32'(outs), 32'(V_DONE));
    nextCycle(); check("e0_idle", 32'(outs), 32'(V_IDLE));
    check("e0_pc_incs", 32'(pcIncs - pcBase), 32'd2);
    check("e0_done_cnt", 32'(doneCount - doneBase), 32'd1);

    // Fetch with ExtLen=3: 2 IR cycles, then 3 EXT cycles. Done at cycle 6, PC +5.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd3;
    nextCycle(); check("e3_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0; ExtLen = 2'd0;
    nextCycle(); check("e3_c2_fh", 32'(outs), 32'(V_FH));
    nextCycle(); check("e3_c3_ext", 32'(outs), 32'(V_EXT));
    nextCycle(); check("e3_c4_ext", 32'(outs), 32'(V_EXT));
    nextCycle(); check("e3_c5_ext", 32'(outs), 32'(V_EXT));
    nextCycle(); check("e3_c6_done", 32'(outs), 32'(V_DONE));
    nextCycle(); check("e3_idle", 32'(outs), 32'(V_IDLE));
    check("e3_pc_incs", 32'(pcIncs - pcBase), 32'd5);
    check("e3_done_cnt", 32'(doneCount - doneBase), 32'd1);

    // Req toggles and ExtLen changes 1->2 while busy. The latched ExtLen=1
    // is still used. Req held high in DONE is accepted only from IDLE.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd1;
    nextCycle(); check("tg_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0; ExtLen = 2'd2;
    nextCycle(); check("tg_c2_fh", 32'(outs), 32'(V_FH));
    Req = 1'b1;
    nextCycle(); check("tg_c3_ext", 32'(outs), 32'(V_EXT));
    Req = 1'b0;
    nextCycle(); check("tg_c4_done", 32'(outs), 32'(V_DONE));
    Req = 1'b1;
    nextCycle(); check("tg_idle_req_ignored", 32'(outs), 32'(V_IDLE));
    check("tg_pc_incs", 32'(pcIncs - pcBase), 32'd3);
    check("tg_done_cnt", 32'(doneCount - doneBase), 32'd1);
    // The request is now accepted from IDLE, with ExtLen=2 latched.
    nextCycle(); check("tg2_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0; ExtLen = 2'd0;
    nextCycle(); check("tg2_c2_fh", 32'(outs), 32'(V_FH));
    nextCycle(); check("tg2_c3_ext", 32'(outs), 32'(V_EXT));
    nextCycle(); check("tg2_c4_ext", 32'(outs), 32'(V_EXT));
    nextCycle(); check("tg2_c5_done", 32'(outs), 32'(V_DONE));
    nextCycle(); check("tg2_idle", 32'(outs), 32'(V_IDLE));
    check("tg2_pc_incs", 32'(pcIncs - pcBase), 32'd7);
    check("tg2_done_cnt", 32'(doneCount - doneBase), 32'd2);

    // Reset asserted during EXT: outputs go idle at once, and no Done occurs.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd3;
    nextCycle(); check("rs_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0;
    nextCycle(); check("rs_c2_fh", 32'(outs), 32'(V_FH));
    nextCycle(); check("rs_c3_ext", 32'(outs), 32'(V_EXT));
    Reset = 1'b0;
    #1;
    check("rs_async_idle", 32'(outs), 32'(V_IDLE));
    @(negedge Clock);
    check("rs_held_idle", 32'(outs), 32'(V_IDLE));
    Reset = 1'b1;
    nextCycle(); check("rs_release_idle", 32'(outs), 32'(V_IDLE));
    check("rs_no_done", 32'(doneCount - doneBase), 32'd0);
    // A new request after release gives a clean fetch.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd0;
    nextCycle(); check("rs2_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0;
    nextCycle(); check("rs2_c2_fh", 32'(outs), 32'(V_FH));
    nextCycle(); check("rs2_c3_done", 32'(outs), 32'(V_DONE));
    nextCycle(); check("rs2_idle", 32'(outs), 32'(V_IDLE));
    check("rs2_pc_incs", 32'(pcIncs - pcBase), 32'd2);
    check("rs2_done_cnt", 32'(doneCount - doneBase), 32'd1);

`ifdef FETCH_ABORT_EN
    // Abort in FETCH_H: the machine is in IDLE on the next edge with no
    // Done. The two PC increments already issued remain.
    pcBase = pcIncs; doneBase = doneCount;
    Req = 1'b1; ExtLen = 2'd2;
    nextCycle(); check("ab_c1_fl", 32'(outs), 32'(V_FL));
    Req = 1'b0;
    nextCycle(); check("ab_c2_fh", 32'(outs), 32'(V_FH));
    Abort = 1'b1;
    nextCycle(); check("ab_idle", 32'(outs), 32'(V_IDLE));
    Abort = 1'b0;
    nextCycle(); check("ab_stay_idle", 32'(outs), 32'(V_IDLE));
    check("ab_no_done", 32'(doneCount - doneBase), 32'd0);
    check("ab_pc_incs", 32'(pcIncs - pcBase), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_INC_FUNSEL, default 2'b01, ARF_FunSel code for PC increment.
REQ-002 SHALL have parameter PC_REGSEL, default 3'b100, ARF_RegSel code that enables PC only.
REQ-003 SHALL have parameter OUTD_PC, default 2'b00, ARF_OutDSel code that puts PC on the memory address.
REQ-004 SHALL have parameter DR_LOAD_FUNSEL, default 2'b10, DR_FunSel code that shifts one byte into DR.
REQ-005 SHALL have ports Clock in 1 (system clock) and Reset in 1 (asynchronous, active-low reset; 0 resets).
REQ-006 SHALL have ports Req in 1 (fetch request) and ExtLen in 2 (extra operand bytes to fetch, 0..3).
REQ-007 SHALL have ports Busy out 1 and Done out 1 (one-cycle completion pulse).
REQ-008 SHALL have ports Mem_CS out 1 (0 enables memory) and Mem_WR out 1 (always 0, read only).
REQ-009 SHALL have ports IR_Write out 1 and IR_LH out 1 (0 loads IR[7:0], 1 loads IR[15:8]).
REQ-010 SHALL have ports ARF_OutDSel out 2, ARF_FunSel out 2 and ARF_RegSel out 3.
REQ-011 SHALL have ports DR_E out 1, DR_FunSel out 2 and MuxCSel out 2 (2'b11 routes MemOut).

Function
REQ-012 SHALL be a registered Moore FSM with states IDLE, FETCH_L, FETCH_H, EXT and DONE; all outputs SHALL decode from the state only.
REQ-013 IDLE: Req=1 -> FETCH_L on the next edge, and ExtLen latched into the 2-bit byte counter CNT in the same edge; Req=0 -> stay in IDLE.
REQ-014 FETCH_L: Mem_CS=0, ARF_OutDSel=OUTD_PC, IR_Write=1, IR_LH=0, ARF_RegSel=PC_REGSEL, ARF_FunSel=PC_INC_FUNSEL; always -> FETCH_H.
REQ-015 FETCH_H: same as FETCH_L except IR_LH=1; CNT=0 -> DONE, else -> EXT.
REQ-016 EXT: Mem_CS=0, ARF_OutDSel=OUTD_PC, PC increment, DR_E=1, DR_FunSel=DR_LOAD_FUNSEL, MuxCSel=2'b11, IR_Write=0; CNT decremented each cycle; -> DONE when CNT=1 at the edge, else stay.
REQ-017 DONE: Done=1 for exactly one cycle; -> IDLE unconditionally; a Req seen in DONE SHALL be ignored.
REQ-018 Busy SHALL be 1 in every state except IDLE.
REQ-019 Outside the active states, Mem_CS=1, IR_Write=0, DR_E=0, ARF_RegSel=3'b000, and ARF_FunSel, DR_FunSel and MuxCSel=2'b00.
REQ-020 Latency from Req accept edge to Done high SHALL be 3+ExtLen cycles; the PC SHALL advance by exactly 2+ExtLen.
REQ-021 Changes to Req or ExtLen while Busy SHALL be ignored.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-023 Reset=0 SHALL immediately force IDLE and CNT=0, with Busy=0, Done=0, Mem_CS=1, IR_Write=0 and DR_E=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the fetch without a Done pulse; the first edge after release SHALL evaluate IDLE.

Configuration
REQ-025 With FETCH_ABORT_EN defined, the block SHALL have an extra input Abort in 1; Abort=1 in any Busy state SHALL force IDLE on the next edge with no Done pulse, and strobes already issued SHALL not be undone.
REQ-026 Without FETCH_ABORT_EN, the Abort port and its logic SHALL be absent and the behaviour SHALL be exactly as in REQ-012..REQ-022.

Verification
REQ-027 Reset=0 then release, Req=0 -> Busy=0, Done=0, Mem_CS=1, all write enables 0.
REQ-028 Req=1, ExtLen=0 -> IR_Write with LH 0 then 1 on consecutive cycles, Done at cycle 3, PC incremented twice.
REQ-029 Req=1, ExtLen=3 -> 2 IR cycles then 3 DR_E cycles with MuxCSel=2'b11, Done at cycle 6, PC +5.
REQ-030 Req toggled and ExtLen changed 1->2 mid-fetch -> sequence unchanged, one Done only, and Req held high through DONE is not accepted until IDLE.
REQ-031 Reset=0 during EXT -> outputs go idle immediately, no Done, and a new Req after release gives a clean fetch.
REQ-032 FETCH_ABORT_EN defined, Abort=1 in FETCH_H -> IDLE on the next edge, Done=0, Busy=0.
